// File: rtl/car_sequencer_pkg.sv
// Shared microsequencer constants and the next-CAR source selector.
package car_sequencer_pkg;

  localparam int unsigned DEF_CAR_BITS    = 6;
  localparam int unsigned DEF_STACK_DEPTH = 4;
  localparam int unsigned DEF_CAR_0       = 'h00;
  localparam int unsigned DEF_CAR_INT0    = 'h38;
  localparam int unsigned DEF_CAR_INT4    = 'h3C;

  // Source of the next control address, in decreasing priority.
  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_HOLD,
    SEL_BRANCH,
    SEL_INT,
    SEL_DISPATCH,
    SEL_CALL,
    SEL_RET,
    SEL_INC
  } car_sel_e;

endpackage

// File: rtl/car_sequencer_stack.sv
// Microcall return-address LIFO; pushes while full and pops while empty are ignored.
module car_stack
  import car_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_CAR_BITS,
  parameter int unsigned DEPTH = DEF_STACK_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (depth == DW'(DEPTH));
  assign empty = (depth == '0);
  assign top   = empty ? '0 : mem[AW'(depth - DW'(1))];

  // Entry storage; contents need no reset since depth gates every read.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem[AW'(depth)] <= din;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else if (clr) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/car_sequencer.sv
// Control Address Register and next-microaddress priority selector.
module car_sequencer
  import car_sequencer_pkg::*;
#(
  parameter int unsigned CAR_BITS    = DEF_CAR_BITS,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int unsigned CAR_0       = DEF_CAR_0,
  parameter int unsigned CAR_INT0    = DEF_CAR_INT0,
  parameter int unsigned CAR_INT4    = DEF_CAR_INT4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rst_req,
  input  logic                                INTREQ,
  input  logic                                IF,
  input  logic                                Br,
  input  logic                                stall,
  input  logic                                ucall,
  input  logic                                uret,
  input  logic [CAR_BITS-1:0]                 utarget,
  input  logic [CAR_BITS-1:0]                 CARnew,
  output logic [CAR_BITS-1:0]                 CAR,
  output logic [CAR_BITS-1:0]                 CARnext,
  output logic                                int_ack,
  output logic [$clog2(STACK_DEPTH+1)-1:0]    depth,
  output logic                                ovf,
  output logic                                unf
);

  logic [CAR_BITS-1:0] car_inc;
  logic [CAR_BITS-1:0] stk_top;
  logic                int_pend;
  logic                int_any;
  logic                stk_push;
  logic                stk_pop;
  logic                stk_clr;
  logic                stk_full;
  logic                stk_empty;
  logic                set_ovf;
  logic                set_unf;
  car_sel_e            sel;

  assign car_inc = CAR + CAR_BITS'(1);
  assign int_any = INTREQ | int_pend;

  // Priority decode of the next-address source and stack side effects.
  always_comb begin
    sel      = SEL_INC;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (rst_req) begin
      sel     = SEL_RESET;
      stk_clr = 1'b1;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (Br) begin
      sel = SEL_BRANCH;
    end else if (IF && int_any) begin
      sel = SEL_INT;
    end else if (IF) begin
      sel = SEL_DISPATCH;
    end else if (ucall) begin
      sel      = SEL_CALL;
      stk_push = 1'b1;
      set_ovf  = stk_full;
      set_unf  = uret;
    end else if (uret) begin
      if (stk_empty) begin
        set_unf = 1'b1;
      end else begin
        sel     = SEL_RET;
        stk_pop = 1'b1;
      end
    end
  end

  // Next-address multiplexer.
  always_comb begin
    CARnext = car_inc;
    case (sel)
      SEL_RESET:    CARnext = CAR_BITS'(CAR_INT4);
      SEL_HOLD:     CARnext = CAR;
      SEL_BRANCH:   CARnext = CAR_BITS'(CAR_0);
      SEL_INT:      CARnext = CAR_BITS'(CAR_INT0);
      SEL_DISPATCH: CARnext = CARnew;
      SEL_CALL:     CARnext = utarget;
      SEL_RET:      CARnext = stk_top;
      default:      CARnext = car_inc;
    endcase
  end

  // CAR, interrupt bookkeeping and sticky stack error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CAR      <= CAR_BITS'(CAR_INT4);
      int_pend <= 1'b0;
      int_ack  <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      CAR     <= CARnext;
      int_ack <= (sel == SEL_INT);
      case (sel)
        SEL_RESET: begin
          int_pend <= 1'b0;
          ovf      <= 1'b0;
          unf      <= 1'b0;
        end
        SEL_INT: begin
          int_pend <= 1'b0;
        end
        default: begin
          int_pend <= int_pend | INTREQ;
          ovf      <= ovf | set_ovf;
          unf      <= unf | set_unf;
        end
      endcase
    end
  end

  car_stack #(
    .WIDTH (CAR_BITS),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (car_inc),
    .top   (stk_top),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

endmodule

// File: tb/tb_car_sequencer.sv
// Scoreboard bench for car_sequencer: directed scenarios plus random traffic vs. a queue-based model.
module tb_car_sequencer;

  localparam int unsigned CB = 6;
  localparam int unsigned SD = 4;
  localparam int unsigned DW = 3;
  localparam int          MODV = 64;

  typedef struct packed {
    logic          rst_req;
    logic          intreq;
    logic          ifs;
    logic          br;
    logic          stall;
    logic          ucall;
    logic          uret;
    logic [CB-1:0] utarget;
    logic [CB-1:0] carnew;
  } stim_t;

  typedef struct {
    int car;
    int ack;
    int depth;
    int ovf;
    int unf;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          rst_req;
  logic          INTREQ;
  logic          IF;
  logic          Br;
  logic          stall;
  logic          ucall;
  logic          uret;
  logic [CB-1:0] utarget;
  logic [CB-1:0] CARnew;
  logic [CB-1:0] CAR;
  logic [CB-1:0] CARnext;
  logic          int_ack;
  logic [DW-1:0] depth;
  logic          ovf;
  logic          unf;

  car_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_req (rst_req),
    .INTREQ  (INTREQ),
    .IF      (IF),
    .Br      (Br),
    .stall   (stall),
    .ucall   (ucall),
    .uret    (uret),
    .utarget (utarget),
    .CARnew  (CARnew),
    .CAR     (CAR),
    .CARnext (CARnext),
    .int_ack (int_ack),
    .depth   (depth),
    .ovf     (ovf),
    .unf     (unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  // Reference model state.
  int m_car;
  int m_pend;
  int m_ovf;
  int m_unf;
  int m_stk[$];

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic stim_t mk(input logic rr, input logic irq, input logic ifs, input logic br,
                               input logic st, input logic uc, input logic ur,
                               input int tgt, input int cnew);
    stim_t s;
    s.rst_req = rr;
    s.intreq  = irq;
    s.ifs     = ifs;
    s.br      = br;
    s.stall   = st;
    s.ucall   = uc;
    s.uret    = ur;
    s.utarget = CB'(tgt);
    s.carnew  = CB'(cnew);
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic drive(input stim_t s);
    rst_req = s.rst_req;
    INTREQ  = s.intreq;
    IF      = s.ifs;
    Br      = s.br;
    stall   = s.stall;
    ucall   = s.ucall;
    uret    = s.uret;
    utarget = s.utarget;
    CARnew  = s.carnew;
  endtask

  // Asynchronous reset for one cycle; model returns to its reset state.
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    drive(idle());
    rst_n = 1'b0;
    m_car  = 'h3C;
    m_pend = 0;
    m_ovf  = 0;
    m_unf  = 0;
    m_stk.delete();
    e.car = m_car; e.ack = 0; e.depth = 0; e.ovf = 0; e.unf = 0;
    sb_q.push_back(e);
    #1;
    chk("reset_car", int'(CAR), 'h3C);
    chk("reset_depth", int'(depth), 0);
    chk("reset_flags", int'({int_ack, ovf, unf}), 0);
  endtask

  // One functional cycle: apply stimulus, advance the model, queue the post-edge expectation.
  task automatic cyc(input stim_t s);
    exp_t e;
    int   ack;
    bit   consumed;
    @(negedge clk);
    rst_n = 1'b1;
    drive(s);
    ack      = 0;
    consumed = 0;
    if (s.rst_req) begin
      m_car  = 'h3C;
      m_pend = 0;
      m_ovf  = 0;
      m_unf  = 0;
      m_stk.delete();
      consumed = 1;
    end else if (s.stall) begin
      // address held, nothing else changes
    end else if (s.br) begin
      m_car = 'h00;
    end else if (s.ifs && (s.intreq || m_pend != 0)) begin
      m_car    = 'h38;
      m_pend   = 0;
      ack      = 1;
      consumed = 1;
    end else if (s.ifs) begin
      m_car = int'(s.carnew);
    end else if (s.ucall) begin
      if (m_stk.size() < SD) m_stk.push_back((m_car + 1) % MODV);
      else m_ovf = 1;
      if (s.uret) m_unf = 1;
      m_car = int'(s.utarget);
    end else if (s.uret) begin
      if (m_stk.size() == 0) begin
        m_car = (m_car + 1) % MODV;
        m_unf = 1;
      end else begin
        m_car = m_stk.pop_back();
      end
    end else begin
      m_car = (m_car + 1) % MODV;
    end
    if (!consumed && s.intreq) m_pend = 1;
    #1;
    chk("carnext", int'(CARnext), m_car);
    e.car = m_car; e.ack = ack; e.depth = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf;
    sb_q.push_back(e);
  endtask

  // Monitor: after each rising edge compare registered outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_car", int'(CAR), e.car);
        chk("sb_int_ack", int'(int_ack), e.ack);
        chk("sb_depth", int'(depth), e.depth);
        chk("sb_ovf", int'(ovf), e.ovf);
        chk("sb_unf", int'(unf), e.unf);
      end
    end
  end

  initial begin
    int          frozen;
    int          wrap_exp[5];
    stim_t       s;
    int unsigned r;

    rst_n = 1'b1;
    drive(idle());
    #1 rst_n = 1'b0;

    do_reset();
    cyc(idle());
    chk("t0_car_after_reset", int'(CAR), 'h3C);

    // T2: latched interrupt taken at a later fetch.
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 0, 'h05));
    cyc(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("t2_car_at_pulse", int'(CAR), 'h05);
    cyc(idle());
    cyc(idle());
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 0, 'h12));
    chk("t2_carnext_int0", int'(CARnext), 'h38);
    cyc(idle());
    chk("t2_int_ack_high", int'(int_ack), 1);
    cyc(idle());
    chk("t2_int_ack_low", int'(int_ack), 0);

    // T3: branch beats interrupt, interrupt kept pending.
    cyc(mk(0, 1, 1, 1, 0, 0, 0, 0, 'h15));
    cyc(idle());
    chk("t3_car_branch", int'(CAR), 'h00);
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 0, 'h22));
    chk("t3_carnext_int0", int'(CARnext), 'h38);

    // T4: single microcall and return.
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 0, 'h07));
    cyc(mk(0, 0, 0, 0, 0, 1, 0, 'h20, 0));
    chk("t4_car_before_call", int'(CAR), 'h07);
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    chk("t4_car_target", int'(CAR), 'h20);
    chk("t4_depth_1", int'(depth), 1);
    cyc(idle());
    chk("t4_car_return", int'(CAR), 'h08);
    chk("t4_depth_0", int'(depth), 0);

    // T5: overflow on fifth nested call, underflow on fifth return.
    cyc(mk(0, 0, 1, 0, 0, 0, 0, 0, 'h01));
    for (int i = 0; i < 5; i++) cyc(mk(0, 0, 0, 0, 0, 1, 0, 'h10 + i, 0));
    for (int i = 0; i < 5; i++) begin
      cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
      if (i == 0) begin
        chk("t5_ovf", int'(ovf), 1);
        chk("t5_depth_full", int'(depth), 4);
      end
    end
    cyc(idle());
    chk("t5_car_after_underflow", int'(CAR), 'h03);
    chk("t5_unf", int'(unf), 1);

    // T6: stall freezes CAR even with fetch; soft reset wins over stall.
    frozen = int'(CAR);
    for (int i = 0; i < 3; i++) begin
      cyc(mk(0, 0, 1, 0, 1, 0, 0, 0, $urandom_range(0, 63)));
      chk("t6_car_frozen", int'(CAR), (frozen + 1) % MODV);
    end
    cyc(mk(1, 0, 1, 0, 1, 0, 0, 0, 'h11));
    cyc(idle());
    chk("t6_car_rst_req", int'(CAR), 'h3C);
    chk("t6_flags_cleared", int'({ovf, unf}), 0);
    chk("t6_depth_cleared", int'(depth), 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r = $urandom;
        s.rst_req = ($urandom_range(0, 31) == 0);
        s.intreq  = ($urandom_range(0, 7) == 0);
        s.ifs     = ($urandom_range(0, 4) == 0);
        s.br      = ($urandom_range(0, 9) == 0);
        s.stall   = ($urandom_range(0, 5) == 0);
        s.ucall   = ($urandom_range(0, 3) == 0);
        s.uret    = ($urandom_range(0, 3) == 0);
        s.utarget = CB'(r);
        s.carnew  = CB'(r >> 8);
        cyc(s);
      end
    end

    // T1: reset mid-run, then free-running increment through the wrap.
    wrap_exp[0] = 'h3C; wrap_exp[1] = 'h3D; wrap_exp[2] = 'h3E;
    wrap_exp[3] = 'h3F; wrap_exp[4] = 'h00;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(idle());
      chk("t1_car_seq", int'(CAR), wrap_exp[i]);
    end
    cyc(idle());

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
